// File: rtl/p2s_rr_arbiter.sv
// Round-robin scheduler sharing one p2s serializer among M requesters.
// Grants bursts of up to MAX_BURST words and registers the chosen word.
module p2s_rr_arbiter #(
    parameter int N         = 8,
    parameter int M         = 4,
    parameter int MAX_BURST = 2,
    parameter int CW        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M*N-1:0]       req_data,
    input  logic [M-1:0]         req_valid,
    output logic [M-1:0]         req_ready,
    output logic [N-1:0]         par_data,
    output logic                 par_valid,
    input  logic                 par_ready,
    output logic [$clog2(M)-1:0] grant_id,
    output logic                 busy,
    output logic [CW-1:0]        word_cnt
);
    localparam int IW = $clog2(M);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t        r_state, w_state_nx;
    logic [IW-1:0] r_last, w_last_nx;
    logic [IW-1:0] r_gid, w_gid_nx;
    logic [BW-1:0] r_burst, w_burst_nx;
    logic [N-1:0]  r_data, w_data_nx;
    logic          r_valid, w_valid_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [M-1:0]  w_ready;
    logic [IW-1:0] w_pick, w_cand;
    logic          w_any;

    // Rotating priority: first valid requester after the last one served
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int k = 1; k <= M; k++) begin
            w_cand = IW'((int'(r_last) + k) % M);
            if (!w_any && req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_last_nx  = r_last;
        w_gid_nx   = r_gid;
        w_burst_nx = r_burst;
        w_data_nx  = r_data;
        w_valid_nx = r_valid;
        w_cnt_nx   = r_cnt;
        w_ready    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_ready[w_pick] = 1'b1;
                    w_data_nx       = req_data[w_pick*N +: N];
                    w_gid_nx        = w_pick;
                    w_valid_nx      = 1'b1;
                    w_burst_nx      = BW'(1);
                    w_state_nx      = OFFER;
                end
            end
            OFFER: begin
                if (par_ready) begin
                    w_cnt_nx = r_cnt + CW'(1);
                    if (r_burst < BW'(MAX_BURST) && req_valid[r_gid]) begin
                        w_ready[r_gid] = 1'b1;
                        w_data_nx      = req_data[r_gid*N +: N];
                        w_burst_nx     = r_burst + BW'(1);
                    end else begin
                        w_last_nx  = r_gid;
                        w_valid_nx = 1'b0;
                        w_burst_nx = '0;
                        w_state_nx = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= IW'(M - 1);
            r_gid   <= '0;
            r_burst <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_last  <= w_last_nx;
            r_gid   <= w_gid_nx;
            r_burst <= w_burst_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign req_ready = w_ready;
    assign par_data  = r_data;
    assign par_valid = r_valid;
    assign grant_id  = r_gid;
    assign busy      = (r_state == OFFER);
    assign word_cnt  = r_cnt;
endmodule

// File: tb/tb_p2s_rr_arbiter.sv
// Self-checking bench for p2s_rr_arbiter: directed scenarios plus
// randomized traffic against a transaction-level round-robin model.
module tb_p2s_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready, req_ready4;
    logic [7:0]  par_data, par_data4;
    logic        par_valid, par_valid4;
    logic        par_ready;
    logic [1:0]  gid, gid4;
    logic        busy, busy4;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;

    int checks = 0;
    int errors = 0;

    int         n_words[4];
    logic [7:0] words[4][8];

    always #5 clk = ~clk;

    p2s_rr_arbiter #(.N(8), .M(4), .MAX_BURST(2), .CW(16)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready), .par_data(par_data), .par_valid(par_valid),
        .par_ready(par_ready), .grant_id(gid), .busy(busy),
        .word_cnt(word_cnt)
    );

    p2s_rr_arbiter #(.N(8), .M(4), .MAX_BURST(2), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_ready(req_ready4), .par_data(par_data4), .par_valid(par_valid4),
        .par_ready(par_ready), .grant_id(gid4), .busy(busy4),
        .word_cnt(word_cnt4)
    );

    // Per-cycle invariants on the ready vector of both instances
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ((req_ready & ~req_valid) != 4'd0 || !$onehot0(req_ready) ||
                (req_ready4 & ~req_valid) != 4'd0 || !$onehot0(req_ready4)) begin
                errors++;
                $display("FAIL ready_invariant: req_ready=%b req_ready4=%b req_valid=%b",
                         req_ready, req_ready4, req_valid);
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        par_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic single_word(input int id, input logic [7:0] d);
        int n;
        req_valid          = 4'd0;
        req_valid[id]      = 1'b1;
        req_data[id*8 +: 8] = d;
        par_ready          = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n == 10) begin
            errors++;
            $display("FAIL single_grant_timeout: id=%0d never granted", id);
        end
        @(posedge clk);
        #1 req_valid = 4'd0;
        @(negedge clk);
        checks++;
        if (par_data !== d || gid !== 2'(id) || par_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_word: data=%h gid=%0d valid=%b want data=%h gid=%0d valid=1",
                     par_data, gid, par_valid, d, id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_data = '0; par_ready = 1'b0;
        #2;
        checks++;
        if (par_data !== 8'd0 || par_valid !== 1'b0 || gid !== 2'd0 ||
            busy !== 1'b0 || word_cnt !== 16'd0 || req_ready !== 4'd0) begin
            errors++;
            $display("FAIL reset_values: data=%h valid=%b gid=%0d busy=%b cnt=%0d rdy=%b want all 0",
                     par_data, par_valid, gid, busy, word_cnt, req_ready);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_data[7:0] = 8'd62;
        par_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || par_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: req_ready=%b par_valid=%b want 0001 0",
                     req_ready, par_valid);
        end
        @(posedge clk);
        #1 req_valid = 4'd0;
        checks++;
        if (par_valid !== 1'b1 || par_data !== 8'd62 || gid !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_offer: valid=%b data=%0d gid=%0d busy=%b want 1 62 0 1",
                     par_valid, par_data, gid, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (word_cnt !== 16'd1 || par_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_count: word_cnt=%0d valid=%b want 1 0", word_cnt, par_valid);
        end
    endtask

    // Run queued traffic; model computes the expected transfer order
    task automatic run_traffic(input bit rand_ready, input string name);
        int         exp_id[$];
        logic [7:0] exp_dat[$];
        int         rem[4];
        int         head[4];
        int         last, found, take, got, total, cyc;
        bit         was_stall, prev_valid;
        logic [7:0] hold_d;
        logic [1:0] hold_g, prev_gid;
        for (int i = 0; i < 4; i++) begin
            rem[i]  = n_words[i];
            head[i] = 0;
        end
        last = 3;
        forever begin
            found = -1;
            for (int k = 1; k <= 4; k++)
                if (found < 0 && rem[(last + k) % 4] > 0) found = (last + k) % 4;
            if (found < 0) break;
            take = (rem[found] > 2) ? 2 : rem[found];
            for (int t = 0; t < take; t++) begin
                exp_id.push_back(found);
                exp_dat.push_back(words[found][n_words[found] - rem[found]]);
                rem[found]--;
            end
            last = found;
        end
        total = exp_id.size();
        got = 0; cyc = 0;
        was_stall = 1'b0; prev_valid = 1'b0;
        hold_d = '0; hold_g = '0; prev_gid = '0;
        while (got < total && cyc < 400) begin
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = head[i] < n_words[i];
                req_data[i*8 +: 8] = req_valid[i] ? words[i][head[i]] : 8'd0;
            end
            par_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (was_stall) begin
                checks++;
                if (par_valid !== 1'b1 || par_data !== hold_d || gid !== hold_g) begin
                    errors++;
                    $display("FAIL %s_hold: valid=%b data=%h gid=%0d want 1 %h %0d",
                             name, par_valid, par_data, gid, hold_d, hold_g);
                end
            end
            if (par_valid && prev_valid && gid !== prev_gid) begin
                errors++;
                $display("FAIL %s_gap: grant %0d followed %0d with no idle cycle",
                         name, gid, prev_gid);
            end
            if (par_valid && par_ready) begin
                checks++;
                if (gid !== 2'(exp_id[got]) || par_data !== exp_dat[got]) begin
                    errors++;
                    $display("FAIL %s_word%0d: gid=%0d data=%h want gid=%0d data=%h",
                             name, got, gid, par_data, exp_id[got], exp_dat[got]);
                end
                got++;
            end
            was_stall  = par_valid && !par_ready;
            hold_d     = par_data;
            hold_g     = gid;
            prev_valid = par_valid;
            prev_gid   = gid;
            for (int i = 0; i < 4; i++)
                if (req_ready[i]) head[i]++;
            @(posedge clk);
            #1;
            cyc++;
        end
        req_valid = '0;
        checks++;
        if (got != total || word_cnt !== 16'(total) || word_cnt4 !== 4'(total)) begin
            errors++;
            $display("FAIL %s_total: got=%0d cnt=%0d cnt4=%0d want %0d",
                     name, got, word_cnt, word_cnt4, total);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_words[i] = 3;
            for (int j = 0; j < 8; j++) words[i][j] = 8'((i << 4) | j);
        end
        run_traffic(1'b0, "round_robin");
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            do_reset();
            for (int i = 0; i < 4; i++) begin
                n_words[i] = $urandom_range(0, 5);
                for (int j = 0; j < 8; j++) words[i][j] = 8'($urandom);
            end
            run_traffic(1'b1, "random");
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        req_valid = 4'b0001;
        req_data  = {8'hd3, 8'hc2, 8'hb1, 8'd52};
        par_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_accept: req_ready=%b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 4'b1110;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (par_valid !== 1'b1 || par_data !== 8'd52 || req_ready !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold: valid=%b data=%0d rdy=%b want 1 52 0000",
                         par_valid, par_data, req_ready);
            end
            @(posedge clk);
            #1;
        end
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (par_valid !== 1'b0 || word_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_release: valid=%b cnt=%0d want 0 1", par_valid, word_cnt);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_next_grant: req_ready=%b want 0010", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_burst_cut();
        do_reset();
        single_word(1, 8'h11);
        req_valid = 4'b1101;
        req_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        par_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL cut_grant2: req_ready=%b want 0100", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (par_valid !== 1'b1 || gid !== 2'd2 || req_ready !== 4'd0) begin
            errors++;
            $display("FAIL cut_offer: valid=%b gid=%0d rdy=%b want 1 2 0000",
                     par_valid, gid, req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (par_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cut_idle: valid=%b busy=%b want 0 0", par_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL cut_next_grant: req_ready=%b want 1000", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        single_word(0, 8'h5a);
        req_valid = 4'b0010;
        req_data[15:8] = 8'ha5;
        par_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (par_data !== 8'd0 || par_valid !== 1'b0 || gid !== 2'd0 ||
            busy !== 1'b0 || word_cnt !== 16'd0 || req_ready !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: data=%h valid=%b gid=%0d busy=%b cnt=%0d rdy=%b want all 0",
                     par_data, par_valid, gid, busy, word_cnt, req_ready);
        end
        req_valid = 4'b1111;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_first_grant: req_ready=%b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        par_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) single_word(i % 4, 8'($urandom));
        checks++;
        if (word_cnt4 !== 4'd1 || word_cnt !== 16'd17) begin
            errors++;
            $display("FAIL wrap: cnt4=%0d cnt=%0d want 1 17", word_cnt4, word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_burst_cut();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
